mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the fetch stage (IF) and the load/store unit (DM).
// - Sequences each transaction: arbitrate, issue, wait a fixed latency, route the response.
// - Produces if_stall/dm_stall, which the pipeline ORs with its hazard stall.
// - Discards fetch responses made stale by a branch/jump redirect.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_starve_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// State and owner encodings used by the top and the bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  function automatic int lat_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of fetch arbitration losses.
// Clear wins over increment.
module arb_starve_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store,
// one transaction at a time with a fixed response latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [BE_W-1:0]   dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = lat_w(MEM_LAT);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  arb_state_e    state_nx;
  arb_owner_e    owner;
  logic [LW-1:0] lat_cnt;
  logic          kill_q;
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic          starve_sat;

  logic idle;
  logic busy;
  logic if_win;
  logic dm_win;
  logic grant;
  logic done;

  // Arbitration is held off while reset is asserted so no strobe escapes.
  assign idle   = (state == ST_IDLE);
  assign busy   = !idle;
  assign if_win = reset_n && idle && if_req && (!dm_req || starve_sat);
  assign dm_win = reset_n && idle && dm_req && !if_win;
  assign grant  = if_win || dm_win;
  assign done   = busy && (lat_cnt == '0) && mem_rvalid;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (dm_win && if_req),
    .clr     (if_win),
    .cnt     (starve_cnt),
    .sat     (starve_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (if_win) begin
          state_nx = ST_BUSY_IF;
        end else if (dm_win) begin
          state_nx = ST_BUSY_DM;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (done) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_IF;
      lat_cnt <= '0;
      we_q    <= 1'b0;
    end else if (grant) begin
      owner   <= dm_win ? OWN_DM : OWN_IF;
      lat_cnt <= LW'(MEM_LAT - 1);
      we_q    <= dm_win && dm_we;
    end else if (busy && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LW'(1);
    end
  end

  // A redirect during the fetch (or its grant cycle) poisons its response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kill_q <= 1'b0;
    end else if (done) begin
      kill_q <= 1'b0;
    end else if (if_kill && (state == ST_BUSY_IF || if_win)) begin
      kill_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req   = grant;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      dm_win: begin
        mem_we    = dm_we;
        mem_be    = dm_be;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      if_win: begin
        mem_be   = '1;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_rvalid = done && owner == OWN_IF && !kill_q && !if_kill;
    dm_rvalid = done && owner == OWN_DM;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !we_q) ? mem_rdata : '0;
  end

  assign if_stall = if_req && !if_rvalid;
  assign dm_stall = dm_req && !dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT 2, STARVE_MAX 4).
// Inputs change 1ns after posedge; outputs are checked 3ns later.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_kill    (if_kill),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_stall   (if_stall),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .dm_stall   (dm_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0;
    if_kill = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_be = 4'h0;
    dm_addr = 32'h0;
    dm_wdata = 32'h0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) tick();
    settle();
    total++;
    if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req);
    else pass_cnt++;
    total++;
    if (if_rvalid !== 1'b0) $display("FAIL reset_if_rvalid got %0b want 0", if_rvalid);
    else pass_cnt++;
    total++;
    if (if_stall !== 1'b1) $display("FAIL reset_if_stall got %0b want 1", if_stall);
    else pass_cnt++;
    tick();
    if_req = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1;
    if_addr = 32'h100;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'hF || mem_we !== 1'b0)
      $display("FAIL fetch_grant got req=%0b addr=%h be=%h we=%0b want 1 100 f 0",
               mem_req, mem_addr, mem_be, mem_we);
    else pass_cnt++;
    tick();
    mem_rdata = 32'h1111_1111;
    mem_rvalid = 1'b1;
    settle();
    total++;
    if (if_rvalid !== 1'b0 || mem_req !== 1'b0 || if_stall !== 1'b1)
      $display("FAIL fetch_wait got rv=%0b req=%0b stall=%0b want 0 0 1",
               if_rvalid, mem_req, if_stall);
    else pass_cnt++;
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_stall !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL fetch_resp got rv=%0b data=%h stall=%0b req=%0b want 1 deadbeef 0 0",
               if_rvalid, if_rdata, if_stall, mem_req);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    if_addr = 32'h104;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104)
      $display("FAIL fetch_next_grant got req=%0b addr=%h want 1 104", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_0104;
    settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE_0104)
      $display("FAIL fetch2_resp got rv=%0b data=%h want 1 cafe0104", if_rvalid, if_rdata);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_contention();
    if_req = 1'b1;
    if_addr = 32'h500;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_be = 4'hF;
    dm_addr = 32'h800;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h800)
        $display("FAIL dm_win%0d got req=%0b addr=%h want 1 800", i, mem_req, mem_addr);
      else pass_cnt++;
      tick();
      tick();
      mem_rvalid = 1'b1;
      mem_rdata = 32'hA000_0000 + i;
      settle();
      total++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hA000_0000 + i || if_rvalid !== 1'b0)
        $display("FAIL dm_resp%0d got rv=%0b data=%h ifrv=%0b want 1 %h 0",
                 i, dm_rvalid, dm_rdata, if_rvalid, 32'hA000_0000 + i);
      else pass_cnt++;
      tick();
      mem_rvalid = 1'b0;
    end
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500)
      $display("FAIL starve_if_win got req=%0b addr=%h want 1 500", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_0500;
    settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h5555_0500 || dm_rvalid !== 1'b0)
      $display("FAIL starve_if_resp got rv=%0b data=%h dmrv=%0b want 1 55550500 0",
               if_rvalid, if_rdata, dm_rvalid);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h800)
      $display("FAIL starve_cleared got req=%0b addr=%h want 1 800", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_kill();
    if_req = 1'b1;
    if_addr = 32'h300;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300)
      $display("FAIL kill_grant got req=%0b addr=%h want 1 300", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    if_kill = 1'b1;
    tick();
    if_kill = 1'b0;
    if_addr = 32'h200;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0_0300;
    settle();
    total++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL kill_suppress got rv=%0b data=%h req=%0b want 0 0 0",
               if_rvalid, if_rdata, mem_req);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL kill_regrant got req=%0b addr=%h want 1 200", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0200;
    if_kill = 1'b1;
    settle();
    total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL kill_same_cycle got rv=%0b want 0", if_rvalid);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    if_addr = 32'h240;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h240)
      $display("FAIL kill_idle_grant got req=%0b addr=%h want 1 240", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    if_kill = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0240;
    settle();
    total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL kill_in_grant got rv=%0b want 0", if_rvalid);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_store();
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_be = 4'b0011;
    dm_addr = 32'h40;
    dm_wdata = 32'h1234;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
        mem_wdata !== 32'h1234 || mem_addr !== 32'h40)
      $display("FAIL store_issue got req=%0b we=%0b be=%b wd=%h addr=%h want 1 1 0011 1234 40",
               mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    settle();
    total++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0 || dm_stall !== 1'b0)
      $display("FAIL store_ack got rv=%0b data=%h stall=%0b want 1 0 0",
               dm_rvalid, dm_rdata, dm_stall);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1;
    dm_addr = 32'h60;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h60)
      $display("FAIL rmid_grant got req=%0b addr=%h want 1 60", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    reset_n = 1'b0;
    dm_req = 1'b0;
    tick();
    reset_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    settle();
    total++;
    if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL rmid_stray got rv=%0b data=%h req=%0b want 0 0 0",
               dm_rvalid, dm_rdata, mem_req);
    else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h900;
    settle();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h900)
      $display("FAIL rmid_idle got req=%0b addr=%h want 1 900", mem_req, mem_addr);
    else pass_cnt++;
    tick();
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_kill();
    test_store();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
